// File: rtl/query_tx_ctrl_if.sv
// Query transmitter bus: request/field inputs, serial bit handshake and
// the sideband to the external CRC-5 engine.
interface query_tx_ctrl_if;
    logic       start;
    logic       dr;
    logic [1:0] m;
    logic       trext;
    logic [1:0] sel;
    logic [1:0] session;
    logic       target;
    logic [3:0] q;
    logic       bit_out;
    logic       bit_vld;
    logic       bit_rdy;
    logic       crc_rst;
    logic       crc_dat;
    logic       crc_vld;
    logic [4:0] crc_val;
    logic       busy;
    logic       done;

    modport master (
        output start, dr, m, trext, sel, session, target, q, bit_rdy, crc_val,
        input  bit_out, bit_vld, crc_rst, crc_dat, crc_vld, busy, done
    );

    modport slave (
        input  start, dr, m, trext, sel, session, target, q, bit_rdy, crc_val,
        output bit_out, bit_vld, crc_rst, crc_dat, crc_vld, busy, done
    );
endinterface

// File: rtl/query_tx_ctrl.sv
// Serialises a Query command (code + fields, MSB first) followed by the
// CRC-5 read back from an external engine, over a valid/ready bit stream.
module query_tx_ctrl #(
    parameter logic [3:0]  CMD_CODE  = 4'b1000,
    parameter int unsigned DATA_BITS = 17
) (
    input logic             clk,
    input logic             rst,
    query_tx_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, INIT, DATA, CRC, DONE} state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   shreg;
    logic [4:0]             cnt;
    logic                   vld_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   crc_rst_r;
    logic                   xfer;
    logic                   crc_bit;
    logic                   out_bit;

    assign xfer = vld_r & bus.bit_rdy;

    // CRC bits are taken live from the engine: it has already absorbed the
    // last data bit by the time the CRC phase begins, and holds still after.
    always_comb begin
        crc_bit = 1'b0;
        case (cnt)
            5'd0:    crc_bit = bus.crc_val[4];
            5'd1:    crc_bit = bus.crc_val[3];
            5'd2:    crc_bit = bus.crc_val[2];
            5'd3:    crc_bit = bus.crc_val[1];
            5'd4:    crc_bit = bus.crc_val[0];
            default: crc_bit = 1'b0;
        endcase
    end

    assign out_bit      = vld_r & ((state == CRC) ? crc_bit : shreg[DATA_BITS-1]);
    assign bus.bit_out  = out_bit;
    assign bus.bit_vld  = vld_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.crc_rst  = crc_rst_r;
    assign bus.crc_vld  = xfer & (state == DATA);
    assign bus.crc_dat  = xfer & (state == DATA) & out_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            vld_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            crc_rst_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg     <= DATA_BITS'({CMD_CODE, bus.dr, bus.m, bus.trext,
                                                 bus.sel, bus.session, bus.target, bus.q});
                        cnt       <= '0;
                        busy_r    <= 1'b1;
                        crc_rst_r <= 1'b1;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    crc_rst_r <= 1'b0;
                    vld_r     <= 1'b1;
                    state     <= DATA;
                end
                DATA: begin
                    if (xfer) begin
                        shreg <= shreg << 1;
                        if (cnt == 5'(DATA_BITS - 1)) begin
                            cnt   <= '0;
                            state <= CRC;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                CRC: begin
                    if (xfer) begin
                        if (cnt == 5'd4) begin
                            cnt    <= '0;
                            vld_r  <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/query_tx_ctrl.md
QUERY_TX_CTRL -- requirements
Module: query_tx_ctrl

Interface
REQ-001 Parameter CMD_CODE, default 4'b1000, Query command code sent first, MSB first.
REQ-002 Parameter DATA_BITS, default 17, payload bit count (command code plus fields), excluding CRC.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to send a Query; honoured only in IDLE.
REQ-006 dr, m[1:0], trext, sel[1:0], session[1:0], target, q[3:0]  input  1/2/1/2/2/1/4  Query fields, sampled when start is accepted.
REQ-007 bit_out  output  1  serial bit to the modulator.
REQ-008 bit_vld  output  1  bit_out valid.
REQ-009 bit_rdy  input  1  downstream accepts bit_out; a transfer occurs when bit_vld and bit_rdy are both high in a cycle.
REQ-010 crc_rst  output  1  preset request to the external CRC-5 engine (x5+x3+1, preset 5'b01001).
REQ-011 crc_dat  output  1  bit fed to the CRC-5 engine.
REQ-012 crc_vld  output  1  CRC-5 engine advance strobe.
REQ-013 crc_val  input  5  current CRC-5 engine register.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the final CRC bit has transferred.

Function
REQ-016 FSM states: IDLE, INIT, DATA, CRC, DONE.
REQ-017 IDLE: when start=1, load the 17-bit shift register with {CMD_CODE, dr, m, trext, sel, session, target, q}, MSB first, clear the bit counter, and go to INIT.
REQ-018 INIT lasts exactly one cycle: crc_rst=1, bit_vld=0; next state is DATA.
REQ-019 DATA: bit_vld=1, bit_out=shift register MSB; on a transfer, crc_vld=1 and crc_dat=bit_out in the same cycle, then shift left and increment the counter.
REQ-020 crc_vld is 0 in DATA cycles without a transfer and in every other state.
REQ-021 After the DATA_BITS-th transfer go to CRC with the counter cleared.
REQ-022 CRC: bit_vld=1, bit_out=crc_val[4-counter] (crc_val[4] first); crc_vld stays 0, so crc_val is stable; on a transfer increment the counter.
REQ-023 After the 5th CRC transfer go to DONE; DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-024 While bit_vld=1 and bit_rdy=0, bit_out and all state are held unchanged.
REQ-025 start outside IDLE is ignored; field inputs are don't-care outside the accept cycle.
REQ-026 Latency with bit_rdy held at 1: start accepted in cycle 0, crc_rst in cycle 1, data bits in cycles 2-18, CRC bits in cycles 19-23, done in cycle 24.
REQ-027 Counter width is 5 bits; it never exceeds DATA_BITS-1 in DATA or 4 in CRC.

Reset
REQ-028 rst=1 forces IDLE at the next edge, including mid-frame, and aborts the frame without completing it.
REQ-029 Reset values: bit_vld=0, bit_out=0, crc_rst=0, crc_dat=0, crc_vld=0, busy=0, done=0, counter=0, shift register=0.
REQ-030 rst takes priority over start in the same cycle.

Verification
REQ-031 Bench stub drives crc_val=5'b10110 (no real engine); dr=0, m=00, trext=0, sel=00, session=00, target=0, q=0100; bit_rdy=1; start pulse -> bit_out sequence 1000_0_00_0_00_00_0_0100 then 1,0,1,1,0; done in cycle 24.
REQ-032 Same stimulus, bit_rdy low on alternate cycles -> same 22-bit sequence; bit_out held during stalls; crc_vld pulses exactly 17 times, each coincident with a data transfer.
REQ-033 Check crc_rst: high for exactly one cycle (cycle 1), before the first crc_vld.
REQ-034 start re-pulsed in cycle 10 with q=1111 -> ignored; frame unchanged; a start after done begins a new frame with the new fields.
REQ-035 rst asserted in cycle 12 -> next cycle IDLE, busy=0, bit_vld=0; no done pulse; a following start produces a complete, correct frame.
REQ-036 start and rst high in the same cycle -> stays in IDLE, busy=0.
